// File: rtl/dff_pipe_pkg.sv
// Shared definitions for the dff_pipe elastic pipeline: count width helper
// and the handshake polarity used by every stage.
package dff_pipe_pkg;

  // An empty stage is always willing to accept a word.
  localparam logic READY_WHEN_EMPTY = 1'b1;

  function automatic int count_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One elastic register stage: holds a valid flag and a data word, and passes
// readiness upstream when empty or when the downstream side is draining.
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  assign ready = valid ? dn_ready : READY_WHEN_EMPTY;

  // Data only loads alongside a valid word so bubbles do not toggle the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage, WIDTH-bit elastic pipeline with valid/ready on both sides,
// flush, programmable reset value and a registered occupancy count.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        flush,
  output logic [count_w(DEPTH)-1:0]   count
);

  localparam int CW = count_w(DEPTH);

  logic [DEPTH:0] vld;
  logic [WIDTH-1:0] dat [DEPTH+1];
  logic in_xfer;
  logic out_xfer;
  logic [CW-1:0] count_nxt;

  assign vld[0] = in_valid;
  assign dat[0] = in_data;

  // Each stage keeps its own ready net so the chain never feeds back into one vector.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic up_rdy;
    logic dn_rdy;

    if (i == DEPTH - 1) begin : g_last
      assign dn_rdy = out_ready;
    end else begin : g_mid
      assign dn_rdy = g_stage[i+1].up_rdy;
    end

    dff_pipe_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .up_valid(vld[i]),
      .up_data (dat[i]),
      .dn_ready(dn_rdy),
      .valid   (vld[i+1]),
      .data    (dat[i+1]),
      .ready   (up_rdy)
    );
  end

  assign in_ready  = g_stage[0].up_rdy;
  assign out_valid = vld[DEPTH];
  assign out_data  = dat[DEPTH];

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    count_nxt = count;
    case ({in_xfer, out_xfer})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Flush empties every stage, so the occupancy drops straight to zero.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: directed vector table, a streaming
// sequence, and randomized traffic against a queue-based reference model.
module tb_dff_pipe;

  localparam int         D  = 3;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, out_ready;
  logic [7:0] in_data;

  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] count;

  logic       in_ready1, out_valid1;
  logic [7:0] out_data1;
  logic [0:0] count1;

  int n_vec = 0;
  int n_err = 0;

  dff_pipe #(.WIDTH(8), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .count(count)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .flush(flush), .count(count1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, fl, iv;
    logic [7:0] d;
    logic       ordy, chk, chk_od, ov;
    logic [7:0] od;
    logic [1:0] cnt;
    logic       ir;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         pos;
  } word_t;

  vec_t  tbl[$];
  word_t q3[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic f, input logic iv,
                                input logic [7:0] d, input logic ordy);
    @(negedge clk);
    reset = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
  endtask

  function automatic void add(logic rst, logic fl, logic iv, logic [7:0] d, logic ordy,
                              logic chk, logic chk_od, logic ov, logic [7:0] od,
                              logic [1:0] cnt, logic ir);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.chk = chk; v.chk_od = chk_od; v.ov = ov; v.od = od; v.cnt = cnt; v.ir = ir;
    tbl.push_back(v);
  endfunction

  initial begin
    logic       e_ov, e_ir, out_x, in_x, v1, e_ir1;
    logic [7:0] last3, d1;
    int         lim, np, exp_cnt;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    // Reset, backpressure, bubble collapse, flush, reset mid-stream.
    add(1,0,0,8'h00,0, 0,0,0,8'h00,0,0);
    add(1,0,0,8'h00,0, 1,1,0,8'hA5,0,1);
    add(0,0,1,8'h10,0, 1,1,0,8'hA5,0,1);
    add(0,0,1,8'h11,0, 1,0,0,8'h00,1,1);
    add(0,0,1,8'h12,0, 1,0,0,8'h00,2,1);
    add(0,0,1,8'h13,0, 1,0,1,8'h10,3,0);
    add(0,0,1,8'h13,0, 1,0,1,8'h10,3,0);
    add(0,0,1,8'h13,1, 1,0,1,8'h10,3,1);
    add(0,0,0,8'h00,1, 1,0,1,8'h11,3,1);
    add(0,0,0,8'h00,1, 1,0,1,8'h12,2,1);
    add(0,0,0,8'h00,1, 1,0,1,8'h13,1,1);
    add(0,0,0,8'h00,0, 1,0,0,8'h00,0,1);
    add(0,0,1,8'h20,0, 1,0,0,8'h00,0,1);
    add(0,0,0,8'h00,0, 1,0,0,8'h00,1,1);
    add(0,0,0,8'h00,0, 1,0,0,8'h00,1,1);
    add(0,0,1,8'h21,0, 1,0,1,8'h20,1,1);
    add(0,0,0,8'h00,0, 1,0,1,8'h20,2,1);
    add(0,0,0,8'h00,0, 1,0,1,8'h20,2,1);
    add(0,0,1,8'h22,0, 1,0,1,8'h20,2,1);
    add(0,1,1,8'h30,0, 1,0,1,8'h20,3,0);
    add(0,0,0,8'h00,1, 1,0,0,8'h00,0,1);
    add(0,0,0,8'h00,1, 1,0,0,8'h00,0,1);
    add(0,0,1,8'h50,0, 1,0,0,8'h00,0,1);
    add(0,0,1,8'h51,1, 1,0,0,8'h00,1,1);
    add(1,0,1,8'h52,0, 1,0,0,8'h00,2,1);
    add(0,0,1,8'h40,1, 1,1,0,8'hA5,0,1);
    add(0,0,0,8'h00,1, 1,0,0,8'h00,1,1);
    add(0,0,0,8'h00,1, 1,0,0,8'h00,1,1);
    add(0,0,0,8'h00,1, 1,0,1,8'h40,1,1);
    add(0,0,0,8'h00,1, 1,0,0,8'h00,0,1);

    foreach (tbl[i]) begin
      apply_stimulus(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      if (tbl[i].chk) begin
        check_output($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
        check_output($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].cnt));
        check_output($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
        if (tbl[i].chk_od || tbl[i].ov)
          check_output($sformatf("row%0d out_data", i), 32'(out_data), 32'(tbl[i].od));
      end
    end

    // Back-to-back streaming of 8'h01..8'h0A with the consumer always ready.
    apply_stimulus(1, 0, 0, 8'h00, 1);
    for (int c = 0; c < 14; c++) begin
      apply_stimulus(0, 0, c < 10, 8'(c + 1), 1);
      if (c < 10) check_output($sformatf("stream%0d in_ready", c), 32'(in_ready), 32'd1);
      e_ov = (c >= 3) && (c <= 12);
      check_output($sformatf("stream%0d out_valid", c), 32'(out_valid), 32'(e_ov));
      if (e_ov) check_output($sformatf("stream%0d out_data", c), 32'(out_data), 32'(c - 2));
      exp_cnt = ((c < 10) ? c : 10) - ((c - 3 < 0) ? 0 : ((c - 3 > 10) ? 10 : c - 3));
      check_output($sformatf("stream%0d count", c), 32'(count), 32'(exp_cnt));
    end

    // Randomized traffic against queue models of both pipeline depths.
    last3 = RV; v1 = 1'b0; d1 = 8'h00;
    for (int k = 0; k < 600; k++) begin
      apply_stimulus((k < 2) || ($urandom_range(0, 59) == 0),
                     $urandom_range(0, 24) == 0,
                     $urandom_range(0, 9) < 7,
                     8'($urandom_range(0, 255)),
                     $urandom_range(0, 9) < 6);

      e_ov  = (q3.size() > 0) && (q3[0].pos == D - 1);
      e_ir  = (q3.size() < D) || out_ready;
      e_ir1 = !v1 || out_ready;
      if (k >= 1) begin
        check_output($sformatf("rnd%0d out_valid", k), 32'(out_valid), 32'(e_ov));
        check_output($sformatf("rnd%0d out_data", k), 32'(out_data), 32'(last3));
        check_output($sformatf("rnd%0d count", k), 32'(count), 32'(q3.size()));
        check_output($sformatf("rnd%0d in_ready", k), 32'(in_ready), 32'(e_ir));
        check_output($sformatf("rnd%0d d1 out_valid", k), 32'(out_valid1), 32'(v1));
        check_output($sformatf("rnd%0d d1 out_data", k), 32'(out_data1), 32'(d1));
        check_output($sformatf("rnd%0d d1 count", k), 32'(count1), 32'(v1));
        check_output($sformatf("rnd%0d d1 in_ready", k), 32'(in_ready1), 32'(e_ir1));
      end

      if (reset) begin
        q3.delete(); last3 = RV;
        v1 = 1'b0; d1 = 8'h00;
      end else begin
        out_x = e_ov && out_ready;
        in_x  = in_valid && e_ir;
        if (out_x) void'(q3.pop_front());
        if (flush) begin
          q3.delete();
        end else begin
          lim = D;
          foreach (q3[j]) begin
            np = (q3[j].pos + 1 < lim) ? q3[j].pos + 1 : q3[j].pos;
            q3[j].pos = np;
            lim = np;
          end
          if (in_x) q3.push_back('{data: in_data, pos: 0});
          if ((q3.size() > 0) && (q3[0].pos == D - 1)) last3 = q3[0].data;
        end
        if (flush) begin
          v1 = 1'b0;
        end else if (e_ir1) begin
          v1 = in_valid;
          if (in_valid) d1 = in_data;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
